nasti_stream_mux_arbiter: RTL
=============================

// Module: nasti_stream_mux_arbiter
// PURPOSE
//  Packet-granular round-robin arbiter/sequencer for nasti_stream_mux. Watches per-port t_valid
//  requests, issues a one-cycle enable plus select to the mux, then holds off until the output
//  stream completes its packet (t_last handshake). Also reports beat count, packet-done and a stall watchdog.
// PARAMETERS
//  N_PORT        1    number of stream source ports (same value as the mux)
//  SELECT_WIDTH  (N_PORT>1 ? $clog2(N_PORT) : 1)  select width; N_PORT=1 must still elaborate
//  BEAT_WIDTH    16   width of per-packet beat counter (saturating)
//  STALL_CYCLES  1024 BUSY cycles with no output handshake before timeout_err sets; 0 disables
// PORTS
//  aclk         in   1             clock
//  areset       in   1             asynchronous reset, active-high
//  req          in   N_PORT        per-port t_valid from mux master side
//  port_en      in   N_PORT        per-port arbitration mask; 0 = never granted
//  s_valid      in   1             mux output t_valid
//  s_ready      in   1             mux output t_ready
//  s_last       in   1             mux output t_last
//  enable       out  1             to mux enable; registered, 1-cycle pulse per grant
//  select       out  SELECT_WIDTH  to mux select; registered, stable from GRANT through end of BUSY
//  busy         out  1             high in GRANT and BUSY
//  grant        out  N_PORT        one-hot of current owner; 0 in IDLE
//  pkt_done     out  1             1-cycle pulse the cycle after final (last) handshake
//  pkt_beats    out  BEAT_WIDTH    beats of last completed packet (incl. last beat); saturates at all-ones
//  timeout_err  out  1             sticky stall flag
//  err_clr      in   1             clears timeout_err (wins over a same-cycle set)
// BEHAVIOUR
//  Reset (async, areset=1): state=IDLE, rr_ptr=0, all outputs 0, beat counter/stall counter 0.
//  FSM: IDLE -> GRANT -> BUSY -> IDLE.
//   IDLE: cand = req & port_en. If cand!=0, pick first set bit at or above rr_ptr (wrapping);
//    register enable=1, select=winner, grant=onehot(winner); go GRANT. Else stay, outputs 0.
//   GRANT (exactly 1 cycle): enable=1; mux latches at end of this cycle. Next: enable=0, go BUSY.
//   BUSY: count beats on s_valid&s_ready. On s_valid&s_ready&s_last: go IDLE, rr_ptr=winner+1
//    (wraps N_PORT-1 -> 0), pkt_beats<=count+1 (saturating), pkt_done=1 next cycle, grant<=0, select<=0.
//  Latency: req high in IDLE at cycle t -> enable high cycle t+1 -> mux owns t+2. Back-to-back
//   packets: last handshake at t, new enable at t+2 (1 idle cycle; matches mux latch clear at t+1).
//  Grant is held for the whole packet even if req/port_en of owner drops; port_en changes affect
//   only the next arbitration. s_* outside BUSY are ignored (no counting, no watchdog).
//  Single-beat packet (last on first beat): legal; pkt_beats=1.
//  Watchdog: stall counter resets on every handshake and on BUSY entry; reaching STALL_CYCLES sets
//   timeout_err; FSM continues waiting (no abort, mux has no abort).
//  Mid-operation reset: FSM returns IDLE immediately; mux is reset on the same net by the integrator.
//  N_PORT=1: select tied 0, round-robin degenerates to port 0.
// STRUCTURE
//  nasti_stream_pkg: typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_BUSY} arb_state_t.
//  Sub-module nasti_stream_rr_pick: combinational rotate-priority picker
//   (cand, rr_ptr -> valid, idx); reusable by other stream arbiters.
// TESTING
//  1. N_PORT=4, req=4'b0101 constant, port_en=all, 2-beat packets -> grants 0,2,0,2; enable 1 cycle each.
//  2. req=4'b1111, rr_ptr after grant 3 -> next grant port 0 (wrap); order 0,1,2,3,0.
//  3. port_en=4'b1011, req=4'b0100 only -> no enable ever; set port_en[2] -> enable next+1 cycle, select=2.
//  4. 5-beat packet with s_ready low 3 cycles mid-packet -> pkt_beats=5, pkt_done one pulse, busy low after.
//  5. STALL_CYCLES=8, BUSY with s_ready=0 for 8 cycles -> timeout_err=1, stays; err_clr -> 0.
//  6. Assert areset while BUSY on beat 2 -> all outputs 0 same cycle; after release, req=4'b0010 -> grant port 1.

Source files
------------

// File: rtl/nasti_stream_pkg.sv
// Shared types for the nasti_stream mux family: arbiter FSM encoding.
package nasti_stream_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_BUSY  = 2'd2
    } arb_state_t;

    // Select width helper; a single-port mux still carries a 1-bit select.
    function automatic int sel_width(input int n_port);
        return (n_port > 1) ? $clog2(n_port) : 1;
    endfunction

endpackage

// File: rtl/nasti_stream_rr_pick.sv
// Rotate-priority picker: returns the first set candidate at or above
// rr_ptr, wrapping past the top port back to port 0.
module nasti_stream_rr_pick
    import nasti_stream_pkg::*;
#(
    parameter int N_PORT       = 1,
    parameter int SELECT_WIDTH = sel_width(N_PORT)
) (
    input  logic [N_PORT-1:0]       cand,
    input  logic [SELECT_WIDTH-1:0] rr_ptr,
    output logic                    valid,
    output logic [SELECT_WIDTH-1:0] idx
);

    // Scan from the highest rotation offset down so the lowest offset
    // (closest to rr_ptr) is the last write and therefore the winner.
    always_comb begin
        int j;
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        for (int i = N_PORT - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            if (j >= N_PORT) begin
                j = j - N_PORT;
            end
            if (cand[j]) begin
                valid = 1'b1;
                idx   = SELECT_WIDTH'(j);
            end
        end
    end

endmodule

// File: rtl/nasti_stream_mux_arbiter.sv
// Packet-granular round-robin arbiter for nasti_stream_mux. Grants one port
// per packet, pulses enable for a single cycle, then waits for the t_last
// handshake on the mux output before arbitrating again. Also reports the
// beat count of each finished packet and a sticky stall watchdog.
module nasti_stream_mux_arbiter
    import nasti_stream_pkg::*;
#(
    parameter int N_PORT       = 1,
    parameter int SELECT_WIDTH = (N_PORT > 1) ? $clog2(N_PORT) : 1,
    parameter int BEAT_WIDTH   = 16,
    parameter int STALL_CYCLES = 1024
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [N_PORT-1:0]       req,
    input  logic [N_PORT-1:0]       port_en,
    input  logic                    s_valid,
    input  logic                    s_ready,
    input  logic                    s_last,
    output logic                    enable,
    output logic [SELECT_WIDTH-1:0] select,
    output logic                    busy,
    output logic [N_PORT-1:0]       grant,
    output logic                    pkt_done,
    output logic [BEAT_WIDTH-1:0]   pkt_beats,
    output logic                    timeout_err,
    input  logic                    err_clr
);

    // Watchdog counter is sized to hold STALL_CYCLES itself so it can park
    // there once the flag has fired instead of wrapping and re-firing.
    localparam int STALL_W = (STALL_CYCLES > 0) ? $clog2(STALL_CYCLES + 1) : 1;
    localparam bit WDOG_ON = (STALL_CYCLES > 0);
    localparam logic [STALL_W-1:0] STALL_MAX  = STALL_W'(STALL_CYCLES);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'((STALL_CYCLES > 0) ? STALL_CYCLES - 1 : 0);
    localparam logic [SELECT_WIDTH-1:0] TOP_PORT = SELECT_WIDTH'(N_PORT - 1);

    arb_state_t                state;
    logic [SELECT_WIDTH-1:0]   rr_ptr;
    logic [SELECT_WIDTH-1:0]   sel_q;
    logic [BEAT_WIDTH-1:0]     beat_cnt;
    logic [BEAT_WIDTH-1:0]     beat_inc;
    logic [STALL_W-1:0]        stall_cnt;
    logic [N_PORT-1:0]         cand;
    logic                      pick_valid;
    logic [SELECT_WIDTH-1:0]   pick_idx;
    logic [N_PORT-1:0]         pick_onehot;
    logic [SELECT_WIDTH-1:0]   next_ptr;
    logic                      hs;
    logic                      in_busy;

    assign cand     = req & port_en;
    assign hs       = s_valid & s_ready;
    assign in_busy  = (state == ARB_BUSY);
    assign busy     = (state != ARB_IDLE);
    assign beat_inc = (beat_cnt == '1) ? beat_cnt : beat_cnt + 1'b1;
    assign next_ptr = (sel_q == TOP_PORT) ? '0 : sel_q + 1'b1;

    // With a single port there is nothing to choose; keep the mux select at 0.
    assign select = (N_PORT == 1) ? '0 : sel_q;

    nasti_stream_rr_pick #(
        .N_PORT       (N_PORT),
        .SELECT_WIDTH (SELECT_WIDTH)
    ) u_pick (
        .cand   (cand),
        .rr_ptr (rr_ptr),
        .valid  (pick_valid),
        .idx    (pick_idx)
    );

    // One-hot image of the winning index, registered into grant on a win.
    always_comb begin
        pick_onehot           = '0;
        pick_onehot[pick_idx] = 1'b1;
    end

    // Arbitration FSM: IDLE picks a winner, GRANT pulses enable for the mux
    // latch, BUSY counts beats until the final handshake of the packet.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            sel_q     <= '0;
            grant     <= '0;
            enable    <= 1'b0;
            pkt_done  <= 1'b0;
            pkt_beats <= '0;
            beat_cnt  <= '0;
        end else begin
            enable   <= 1'b0;
            pkt_done <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        state  <= ARB_GRANT;
                        enable <= 1'b1;
                        sel_q  <= pick_idx;
                        grant  <= pick_onehot;
                    end
                end
                ARB_GRANT: begin
                    state    <= ARB_BUSY;
                    beat_cnt <= '0;
                end
                ARB_BUSY: begin
                    if (hs) begin
                        if (s_last) begin
                            // Owner keeps the port until here regardless of
                            // its req/port_en; pointer moves past it.
                            state     <= ARB_IDLE;
                            rr_ptr    <= next_ptr;
                            pkt_beats <= beat_inc;
                            pkt_done  <= 1'b1;
                            grant     <= '0;
                            sel_q     <= '0;
                            beat_cnt  <= '0;
                        end else begin
                            beat_cnt <= beat_inc;
                        end
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Stall counter: cleared on BUSY entry and on each handshake, counts
    // BUSY cycles without a handshake and parks at STALL_CYCLES.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            stall_cnt <= '0;
        end else if (state == ARB_GRANT) begin
            stall_cnt <= '0;
        end else if (in_busy) begin
            if (hs) begin
                stall_cnt <= '0;
            end else if (stall_cnt != STALL_MAX) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

    // Sticky timeout flag; a clear request beats a same-cycle set. The FSM
    // keeps waiting because the mux has no way to abort a packet.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            timeout_err <= 1'b0;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end else if (WDOG_ON && in_busy && !hs && (stall_cnt == STALL_LAST)) begin
            timeout_err <= 1'b1;
        end
    end

endmodule
